// File: rtl/chain_arbiter_pkg.sv
// Shared types and default sizing for the chain arbiter slice.
package chain_arbiter_pkg;

  typedef enum logic {
    OWNER0 = 1'b0,
    OWNER1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWNER0};

  localparam int DEF_DW        = 8;
  localparam int DEF_CHAIN_NUM = 4;
  localparam int DEF_CW        = 16;

endpackage

// File: rtl/chain_arbiter_flipflop_chain.sv
// Fixed-latency register chain: q is d delayed by exactly CHAIN_NUM cycles.
module flipflop_chain #(
  parameter int DW        = 8,
  parameter int CHAIN_NUM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] stage [CHAIN_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHAIN_NUM; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < CHAIN_NUM; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[CHAIN_NUM-1];

endmodule

// File: rtl/chain_arbiter.sv
// Two-requester round-robin arbiter sharing one fixed-latency chain; a tag
// pipeline running alongside the chain routes each word back to its owner.
import chain_arbiter_pkg::*;

module chain_arbiter #(
  parameter int DW        = DEF_DW,
  parameter int CHAIN_NUM = DEF_CHAIN_NUM,
  parameter int CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req0_ready,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp_data,
  output logic [CW-1:0] grant_cnt0,
  output logic [CW-1:0] grant_cnt1
);

  owner_t        last_grant;
  tag_t          tags [CHAIN_NUM];
  logic          sel1;
  logic          grant_ok;
  logic          accept;
  logic [DW-1:0] chain_in;

  // Requester 1 wins when it is alone, or when requester 0 was served last.
  assign sel1     = req1_valid && (!req0_valid || (last_grant == OWNER0));
  assign grant_ok = rst_n && en && !flush;

  assign req0_ready = grant_ok && req0_valid && !sel1;
  assign req1_ready = grant_ok && sel1;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    chain_in = '0;
    if (req1_ready)      chain_in = req1_data;
    else if (req0_ready) chain_in = req0_data;
  end

  flipflop_chain #(
    .DW        (DW),
    .CHAIN_NUM (CHAIN_NUM)
  ) u_chain (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (chain_in),
    .q     (rsp_data)
  );

  // Flush wipes every tag so nothing already in the chain is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHAIN_NUM; i++) tags[i] <= TAG_IDLE;
    end else if (flush) begin
      for (int i = 0; i < CHAIN_NUM; i++) tags[i] <= TAG_IDLE;
    end else begin
      tags[0] <= '{valid: accept, owner: (req1_ready ? OWNER1 : OWNER0)};
      for (int i = 1; i < CHAIN_NUM; i++) tags[i] <= tags[i-1];
    end
  end

  assign rsp0_valid = tags[CHAIN_NUM-1].valid && (tags[CHAIN_NUM-1].owner == OWNER0);
  assign rsp1_valid = tags[CHAIN_NUM-1].valid && (tags[CHAIN_NUM-1].owner == OWNER1);

  // Reset history favours requester 0 for the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= OWNER1;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) last_grant <= OWNER0;
      if (req1_ready) last_grant <= OWNER1;
      if (req0_ready && (grant_cnt0 != {CW{1'b1}})) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && (grant_cnt1 != {CW{1'b1}})) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end

endmodule

// File: doc/chain_arbiter.md
CHAIN_ARBITER -- requirements
Module: chain_arbiter

Interface
REQ-001 Parameter DW, default 8: data width of every data port and of the shared chain.
REQ-002 Parameter CHAIN_NUM, default 4: stage count of the shared chain, range 1..7.
REQ-003 Parameter CW, default 16: width of each grant counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 en  input  1  accept enable; when low, no new request is granted.
REQ-007 flush  input  1  synchronous clear of all in-flight tracking.
REQ-008 req0_valid / req1_valid  input  1  requester has a word.
REQ-009 req0_data / req1_data  input  DW  requester word.
REQ-010 req0_ready / req1_ready  output  1  word accepted this cycle when valid && ready.
REQ-011 rsp0_valid / rsp1_valid  output  1  delayed word returned to its owner; no backpressure.
REQ-012 rsp_data  output  DW  chain output word, shared by both responses.
REQ-013 grant_cnt0 / grant_cnt1  output  CW  accepted-word counters.

Function
REQ-014 The block SHALL own one flipflop_chain (DW, CHAIN_NUM): chain output equals chain input delayed exactly CHAIN_NUM cycles, with every stage reset to 0.
REQ-015 Grant: at most one readyN high per cycle; readyN = en && reqN_valid && (arbiter selects N).
REQ-016 Arbitration SHALL be round-robin. With both requesters valid, grant the requester not granted most recently. With one valid, grant it regardless of history.
REQ-017 last_grant SHALL update only on an accepted transfer; idle cycles keep it unchanged.
REQ-018 Chain input SHALL be the granted reqN_data, or 0 when no transfer occurs (bubble).
REQ-019 A CHAIN_NUM-deep tag pipeline of {valid, owner} SHALL advance every cycle in lockstep with the chain.
REQ-020 A word accepted in cycle t SHALL appear with rspN_valid=1 for its owner in cycle t+CHAIN_NUM, for exactly one cycle.
REQ-021 rsp0_valid and rsp1_valid SHALL never be high together.
REQ-022 rsp_data SHALL equal the chain output every cycle. Its value when both rspN_valid are low is don't-care.
REQ-023 en low SHALL stop acceptance only; in-flight words still drain and are returned.
REQ-024 flush=1 SHALL clear all tag valids at the next edge, so no in-flight word is returned. Chain data is not cleared.
REQ-025 A transfer accepted in the same cycle as flush SHALL be discarded. readyN SHALL be forced low while flush=1.
REQ-026 grant_cntN SHALL increment by 1 per accepted transfer and saturate at all-ones (no wrap).
REQ-027 Back-to-back transfers every cycle SHALL be sustained, giving full throughput of 1 word/cycle.

Reset
REQ-028 rst_n low SHALL asynchronously clear: tag valids, last_grant (=1, so requester 0 wins first), grant_cnt0/1 (=0), and the chain stages (=0).
REQ-029 During reset, readyN=0, rspN_valid=0, rsp_data=0.
REQ-030 Reset mid-operation SHALL discard all in-flight words; none is returned after release.

Structure
REQ-031 A shared package SHALL hold the owner-tag typedef (1-bit enum: OWNER0, OWNER1) and the default DW/CHAIN_NUM/CW constants.
REQ-032 flipflop_chain SHALL be the only sub-module instance. Arbiter, tag pipeline and counters live in chain_arbiter.

Verification
REQ-033 Single requester: req0 sends 0x0F for one cycle -> rsp0_valid with rsp_data=0x0F exactly 4 cycles later; rsp1_valid stays 0.
REQ-034 Contention: both valid for 6 cycles (req0=0xA0.., req1=0xB0..) -> grants alternate 0,1,0,1,0,1; responses arrive in the same order at +4 cycles; grant_cnt0=grant_cnt1=3.
REQ-035 en low: both valid, en=0 for 5 cycles -> no ready, no new responses; words accepted before en fell are still returned.
REQ-036 Flush: accept 0x0A, 0x0B on consecutive cycles, assert flush 2 cycles later -> neither word is returned; next accepted word 0x0C is returned normally at +4.
REQ-037 Async reset mid-stream: rst_n low between clock edges with 3 words in flight -> outputs clear immediately; no responses after release; the first grant goes to requester 0.
REQ-038 Saturation (CW=4): 20 accepted req1 transfers -> grant_cnt1 holds 0xF.
